bcd_to_binary: RTL and testbench

Sequential converter from packed BCD digits to unsigned binary. It is the inverse of the binary_to_bcd block, and uses reverse double-dabble: one shift-right plus per-digit correction per cycle. It uses valid/ready handshakes on both sides, so it can sit between a BCD keypad/display datapath and binary arithmetic. It also flags illegal digits (greater than 9) and results that do not fit in BIN_W bits.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_digit_adjust.sv | 17 +
 rtl/bcd_to_binary.sv | 111 +++++++++++
 tb/tb_bcd_to_binary.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and helpers for the BCD <-> binary converters.
// Rev 1.0
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int BCD_NIBBLE_W  = 4;
  localparam int BCD_MAX_DIGIT = 9;

  function automatic logic is_bcd_digit(input logic [BCD_NIBBLE_W-1:0] d);
    return int'(d) <= BCD_MAX_DIGIT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: reverse double-dabble nibble correction (>= 8 -> -3).
// Rev 1.0
`default_nettype none

module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] digit_in,
  output logic [BCD_NIBBLE_W-1:0] digit_out
);

  // A shifted digit of 8+ carries a half-ten from the next digit up; -3 restores BCD.
  assign digit_out = (digit_in >= 4'd8) ? (digit_in - 4'd3) : digit_in;

endmodule

`default_nettype wire

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential packed-BCD to unsigned binary converter (reverse double-dabble).
// Rev 1.0
`default_nettype none

module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BCD_NIBBLE_W*DIGITS-1:0] bcd_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BIN_W-1:0]             bin_out,
  output logic                         err_digit,
  output logic                         ovf,
  output logic                         busy
);

  localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t            state;
  state_t            state_nxt;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_shift;
  logic [BCD_W-1:0]  bcd_adj;
  logic [CNT_W-1:0]  cnt;
  logic              bad_digit;
  logic              last_iter;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  assign sr_shift  = sr >> 1;
  assign last_iter = (cnt == CNT_W'(BIN_W - 1));

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_in  (sr_shift[BIN_W + BCD_NIBBLE_W*i +: BCD_NIBBLE_W]),
      .digit_out (bcd_adj[BCD_NIBBLE_W*i +: BCD_NIBBLE_W])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(bcd_in[BCD_NIBBLE_W*i +: BCD_NIBBLE_W])) bad_digit = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = bad_digit ? DONE : CONVERT;
      CONVERT: if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      cnt       <= '0;
      bin_out   <= '0;
      err_digit <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (bad_digit) begin
              bin_out   <= '0;
              err_digit <= 1'b1;
              ovf       <= 1'b0;
            end else begin
              sr  <= {bcd_in, {BIN_W{1'b0}}};
              cnt <= '0;
            end
          end
        end
        CONVERT: begin
          sr  <= {bcd_adj, sr_shift[BIN_W-1:0]};
          cnt <= cnt + CNT_W'(1);
          // Anything left in the BCD field after BIN_W shifts did not fit.
          if (last_iter) begin
            bin_out   <= sr_shift[BIN_W-1:0];
            ovf       <= |bcd_adj;
            err_digit <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: directed self-checking bench for bcd_to_binary.
// Rev 1.0
`default_nettype none

module tb_bcd_to_binary;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid = 1'b0;
  logic [7:0] bcd_in = 8'h00;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, err_digit, ovf, busy;
  logic [6:0] bin_out;

  logic       in_valid5 = 1'b0;
  logic [7:0] bcd_in5 = 8'h00;
  logic       out_ready5 = 1'b0;
  logic       in_ready5, out_valid5, err_digit5, ovf5, busy5;
  logic [4:0] bin_out5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_to_binary #(.DIGITS(2), .BIN_W(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bcd_in(bcd_in),
    .out_valid(out_valid), .out_ready(out_ready), .bin_out(bin_out),
    .err_digit(err_digit), .ovf(ovf), .busy(busy)
  );

  bcd_to_binary #(.DIGITS(2), .BIN_W(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .bcd_in(bcd_in5),
    .out_valid(out_valid5), .out_ready(out_ready5), .bin_out(bin_out5),
    .err_digit(err_digit5), .ovf(ovf5), .busy(busy5)
  );

  // Present one input to the default DUT, count edges (accepting edge = 1) until out_valid.
  task automatic send(input logic [7:0] v, output int lat);
    bcd_in = v; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; bcd_in = 8'hEE;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic send5(input logic [7:0] v, output int lat);
    bcd_in5 = v; in_valid5 = 1'b1; out_ready5 = 1'b0;
    @(posedge clk); #1;
    in_valid5 = 1'b0; bcd_in5 = 8'hEE;
    lat = 1;
    while (!out_valid5 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1; out_ready5 = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; out_ready5 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, bin_out, err_digit, ovf, busy, in_ready} !== {1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got ov=%b bin=%0d err=%b ovf=%b busy=%b ir=%b, want 0 0 0 0 0 1",
               out_valid, bin_out, err_digit, ovf, busy, in_ready);
    end
    checks++;
    if ({out_valid5, bin_out5, busy5, in_ready5} !== {1'b0, 5'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state5: got ov=%b bin=%0d busy=%b ir=%b, want 0 0 0 1",
               out_valid5, bin_out5, busy5, in_ready5);
    end
    rst = 1'b0;
  endtask

  task automatic test_convert();
    logic [7:0] vin [4] = '{8'h00, 8'h31, 8'h21, 8'h99};
    logic [6:0] vexp [4] = '{7'd0, 7'd31, 7'd21, 7'd99};
    int lat;
    for (int i = 0; i < 4; i++) begin
      send(vin[i], lat);
      checks++;
      if (lat !== 8) begin
        errors++;
        $display("FAIL convert_latency[%h]: got %0d, want 8", vin[i], lat);
      end
      checks++;
      if ({bin_out, err_digit, ovf} !== {vexp[i], 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL convert_value[%h]: got bin=%0d err=%b ovf=%b, want bin=%0d err=0 ovf=0",
                 vin[i], bin_out, err_digit, ovf, vexp[i]);
      end
      release_result();
    end
  endtask

  task automatic test_illegal();
    logic [7:0] vin [2] = '{8'h1A, 8'hF0};
    int lat;
    for (int i = 0; i < 2; i++) begin
      send(vin[i], lat);
      checks++;
      if (lat !== 1) begin
        errors++;
        $display("FAIL illegal_latency[%h]: got %0d, want 1", vin[i], lat);
      end
      checks++;
      if ({bin_out, err_digit, ovf} !== {7'd0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL illegal_value[%h]: got bin=%0d err=%b ovf=%b, want bin=0 err=1 ovf=0",
                 vin[i], bin_out, err_digit, ovf);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send(8'h47, lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, bin_out, in_ready, busy} !== {1'b1, 7'd47, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got ov=%b bin=%0d ir=%b busy=%b, want 1 47 0 1",
                 c, out_valid, bin_out, in_ready, busy);
      end
    end
    release_result();
    checks++;
    if ({out_valid, in_ready, bin_out} !== {1'b0, 1'b1, 7'd47}) begin
      errors++;
      $display("FAIL hold_release: got ov=%b ir=%b bin=%0d, want 0 1 47",
               out_valid, in_ready, bin_out);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] vin [3] = '{8'h50, 8'h31, 8'h99};
    logic [4:0] vexp [3] = '{5'd18, 5'd31, 5'd3};
    logic       oexp [3] = '{1'b1, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      send5(vin[i], lat);
      checks++;
      if (lat !== 6) begin
        errors++;
        $display("FAIL ovf_latency[%h]: got %0d, want 6", vin[i], lat);
      end
      checks++;
      if ({bin_out5, ovf5, err_digit5} !== {vexp[i], oexp[i], 1'b0}) begin
        errors++;
        $display("FAIL ovf_value[%h]: got bin=%0d ovf=%b err=%b, want bin=%0d ovf=%b err=0",
                 vin[i], bin_out5, ovf5, err_digit5, vexp[i], oexp[i]);
      end
      release_result();
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bcd_in = 8'h99; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({out_valid, bin_out, in_ready, busy} !== {1'b0, 7'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got ov=%b bin=%0d ir=%b busy=%b, want 0 0 1 0",
               out_valid, bin_out, in_ready, busy);
    end
    send(8'h42, lat);
    checks++;
    if ({lat == 8, bin_out, err_digit, ovf} !== {1'b1, 7'd42, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL after_reset_42: got lat=%0d bin=%0d err=%b ovf=%b, want lat=8 bin=42 err=0 ovf=0",
               lat, bin_out, err_digit, ovf);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_convert();
    test_illegal();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
